register_file_hs: RTL
=====================

# register_file_hs

Parametrised Mic-1 register file with handshaked, variable-latency memory ports. It replaces the fixed-timing register file plus RAM pairing in the datapath. It holds the MAR/MDR/PC/MBR and general registers, drives the B bus, and accepts C-bus writes. It runs independent data (MAR/MDR) and fetch (PC/MBR) memory channels, and asserts `stall` to freeze the microsequencer when a channel is not ready.

## Interface
- `NBITS`, 32, datapath and register width.
- `NREGS`, 10, number of registers on the C bus (indices 0..NREGS-1); `NREGS >= 5`.
- `BSEL`, 4, encoded B-bus select width; `2**BSEL >= NREGS+1`.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `c_bus`  in  NBITS  ALU/shifter result.
- `write_c`  in  NREGS  one-hot-or-zero C-bus write enables, bit i writes register i.
- `enable_b`  in  BSEL  encoded B-bus source select.
- `b_bus`  out  NBITS  selected register value.
- `mem_control`  in  3  {wr, rd, fetch} request for this microinstruction.
- `stall`  out  1  combinational; microinstruction must be held and retried next cycle.
- `d_req`  out  1  data request valid.
- `d_we`  out  1  1 = write, 0 = read.
- `d_addr`  out  NBITS  word address (MAR).
- `d_wdata`  out  NBITS  write data (MDR).
- `d_ack`  in  1  single-cycle completion strobe.
- `d_rdata`  in  NBITS  read data, valid with `d_ack`.
- `f_req`  out  1  fetch request valid.
- `f_addr`  out  NBITS  byte address (PC).
- `f_ack`  in  1  fetch completion strobe.
- `f_rdata`  in  8  fetched byte, valid with `f_ack`.

## Operation
- Registers: MAR=0, MDR=1, PC=2, MBR=3 (8 bits; low 8 bits of `c_bus` on write), others general.
- B-bus select codes: 0..NREGS-1 select the register directly (MAR reads as its value). Code 3 is MBR sign-extended (MBR). Code NREGS is MBRU, MBR zero-extended. Other codes read 0.
- Data channel FSM has three states: D_IDLE, D_RD and D_WR.
  - rd or wr accepted in D_IDLE moves to D_RD/D_WR, with `d_req`=1 from the next cycle.
  - `d_ack` returns the FSM to D_IDLE; a read writes MDR <= `d_rdata` on that edge.
  - A new rd/wr in the ack cycle is accepted with no stall and goes back to back.
- Fetch channel FSM has two states, F_IDLE and F_BUSY, with the same rules. `f_ack` writes MBR <= `f_rdata`.
- Address and write data are captured at issue from next-state values. If the same microinstruction writes MAR, MDR or PC via `c_bus`, the new value is used.
- `d_addr`, `d_we` and `d_wdata` are held stable while `d_req`=1. `f_addr` is held stable while `f_req`=1.
- rd and wr asserted together: wr wins and rd is ignored.
- `stall`=1 when any of the following holds:
  - rd or wr is requested while the data FSM is not idle and `d_ack`=0.
  - fetch is requested while F_BUSY and `f_ack`=0.
  - `enable_b` selects MDR while in D_RD and `d_ack`=0.
  - `enable_b` selects MBR or MBRU while in F_BUSY and `f_ack`=0.
- While `stall`=1, all `write_c` and `mem_control` inputs are ignored. Acks are still consumed.
- Bypass: in the `d_ack` cycle of a read, `b_bus` selecting MDR returns `d_rdata`. In the `f_ack` cycle, MBR and MBRU return the extended `f_rdata`.
- Load results beat the C bus: if `write_c[MDR]` coincides with a read `d_ack`, MDR takes `d_rdata`. The same rule applies to MBR and `f_ack`.
- An ack while the channel is idle is ignored.

## Timing
- Reset: all registers are 0 and both FSMs go idle. `d_req`, `f_req`, `d_we` and `stall` are 0. `b_bus` is 0 for every code.
- Reset mid-transaction drops the request next cycle, and a late ack is ignored.
- Request issued in cycle k: `req` is high from k+1, and the ack arrives at k+1+L (L >= 0). MDR/MBR updates at the end of cycle k+1+L and is readable via bypass in that cycle.
- C-bus writes land at the end of the cycle; `b_bus` reflects them next cycle.

## Structure
- Shared package: register index constants (MAR, MDR, PC, MBR, MBRU code), `mem_control` bit positions, and FSM state enums.
- One sub-module, `mem_channel`, holds the per-channel FSM, stall term and address/data hold. It is instantiated twice: once for data, once for fetch with write tied off.

## Test plan
- Reset with all acks high -> `b_bus`=0 for every code, `d_req`=`f_req`=0, `stall`=0.
- c_bus=0x40, write MAR with rd; `d_ack` 3 cycles later with `d_rdata`=0xDEADBEEF:
  - -> `d_addr`=0x40 at the next cycle, `d_we`=0.
  - -> Selecting MDR stalls until the ack cycle, then `b_bus`=0xDEADBEEF via bypass.
- Fetch with PC=5, `f_rdata`=0x80 -> `f_addr`=5; MBR reads 0xFFFFFF80 and MBRU reads 0x00000080.
- wr pending with no ack, then a second rd -> `stall`=1 and `write_c` is ignored. In the ack cycle rd is accepted and `d_req` stays 1 with the new `d_we`=0.
- `write_c[MDR]` with c_bus=0x1 in the same cycle as a read `d_ack` with 0x2 -> MDR=0x2.
- rd and wr together -> `d_we`=1. Reset asserted during D_WR -> `d_req`=0 next cycle, and a later ack leaves MDR unchanged.

Source files
------------

// File: rtl/register_file_hs_pkg.sv
// Shared definitions for the Mic-1 handshaked register file: register indices,
// mem_control bit positions and channel FSM states.
package register_file_hs_pkg;

  localparam int MAR_IDX = 0;
  localparam int MDR_IDX = 1;
  localparam int PC_IDX  = 2;
  localparam int MBR_IDX = 3;
  localparam int MBR_W   = 8;

  localparam int MC_FETCH = 0;
  localparam int MC_RD    = 1;
  localparam int MC_WR    = 2;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_RD   = 2'd1,
    D_WR   = 2'd2
  } d_state_e;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_BUSY = 1'b1
  } f_state_e;

  // MBRU takes the first B-bus code past the last real register.
  function automatic int mbru_code(input int nregs);
    return nregs;
  endfunction

endpackage

// File: rtl/register_file_hs_if.sv
// Datapath and memory-side signals of the register file, bundled with
// modports for the register file (slave) and its environment (master).
interface register_file_hs_if #(
  parameter int NBITS = 32,
  parameter int NREGS = 10,
  parameter int BSEL  = 4
);

  logic [NBITS-1:0] c_bus;
  logic [NREGS-1:0] write_c;
  logic [BSEL-1:0]  enable_b;
  logic [NBITS-1:0] b_bus;
  logic [2:0]       mem_control;
  logic             stall;

  logic             d_req;
  logic             d_we;
  logic [NBITS-1:0] d_addr;
  logic [NBITS-1:0] d_wdata;
  logic             d_ack;
  logic [NBITS-1:0] d_rdata;

  logic             f_req;
  logic [NBITS-1:0] f_addr;
  logic             f_ack;
  logic [7:0]       f_rdata;

  modport slave (
    input  c_bus, write_c, enable_b, mem_control, d_ack, d_rdata, f_ack, f_rdata,
    output b_bus, stall, d_req, d_we, d_addr, d_wdata, f_req, f_addr
  );

  modport master (
    output c_bus, write_c, enable_b, mem_control, d_ack, d_rdata, f_ack, f_rdata,
    input  b_bus, stall, d_req, d_we, d_addr, d_wdata, f_req, f_addr
  );

endinterface

// File: rtl/register_file_hs_mem_channel.sv
// One request/ack memory channel: issue FSM, its stall term and the
// address/data hold registers. The fetch channel ties i_wr low.
module register_file_hs_mem_channel
  import register_file_hs_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_rd,
  input  logic             i_wr,
  input  logic             i_accept,
  input  logic             i_ack,
  input  logic [NBITS-1:0] i_addr_next,
  input  logic [NBITS-1:0] i_wdata_next,
  output logic             o_req,
  output logic             o_we,
  output logic [NBITS-1:0] o_addr,
  output logic [NBITS-1:0] o_wdata,
  output logic             o_rd_busy,
  output logic             o_load,
  output logic             o_stall
);

  d_state_e         r_state;
  logic             r_we;
  logic [NBITS-1:0] r_addr;
  logic [NBITS-1:0] r_wdata;
  logic             w_idle;
  logic             w_issue;

  assign w_idle  = (r_state == D_IDLE);
  // The ack cycle frees the channel, so a new request then goes back to back.
  assign w_issue = i_accept & (i_rd | i_wr) & (w_idle | i_ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= D_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_issue) begin
      r_state <= i_wr ? D_WR : D_RD;
      r_we    <= i_wr;
      r_addr  <= i_addr_next;
      r_wdata <= i_wdata_next;
    end else if (i_ack && !w_idle) begin
      r_state <= D_IDLE;
    end else begin
      r_state <= r_state;
    end
  end

  assign o_req     = ~w_idle;
  assign o_we      = r_we;
  assign o_addr    = r_addr;
  assign o_wdata   = r_wdata;
  assign o_rd_busy = (r_state == D_RD);
  assign o_load    = o_rd_busy & i_ack;
  assign o_stall   = (i_rd | i_wr) & ~w_idle & ~i_ack;

endmodule

// File: rtl/register_file_hs.sv
// Mic-1 register file with independent handshaked data (MAR/MDR) and
// fetch (PC/MBR) channels; stall freezes the microsequencer.
module register_file_hs
  import register_file_hs_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int NREGS = 10,
  parameter int BSEL  = 4
) (
  input logic               clk,
  input logic               reset,
  register_file_hs_if.slave bus
);

  localparam int              MBRU_CODE = mbru_code(NREGS);
  localparam logic [BSEL-1:0] SEL_MDR   = BSEL'(MDR_IDX);
  localparam logic [BSEL-1:0] SEL_MBR   = BSEL'(MBR_IDX);
  localparam logic [BSEL-1:0] SEL_MBRU  = BSEL'(MBRU_CODE);

  logic [NBITS-1:0] r_regs [NREGS];
  logic [NBITS-1:0] w_next [NREGS];

  logic             w_wr;
  logic             w_rd;
  logic             w_fetch;
  logic             w_stall;
  logic             w_accept;
  logic             w_d_stall;
  logic             w_d_rd_busy;
  logic             w_d_load;
  logic             w_f_stall;
  logic             w_f_load;
  logic             w_f_req;
  logic             w_f_we_unused;
  logic             w_f_rd_busy_unused;
  logic [NBITS-1:0] w_f_wdata_unused;
  logic [MBR_W-1:0] w_mbr_byte;
  logic [NBITS-1:0] w_b_bus;

  assign w_wr    = bus.mem_control[MC_WR];
  assign w_rd    = bus.mem_control[MC_RD] & ~w_wr;
  assign w_fetch = bus.mem_control[MC_FETCH];

  // Reading a load target before its ack would return stale data.
  assign w_stall = w_d_stall | w_f_stall
                 | ((bus.enable_b == SEL_MDR) & w_d_rd_busy & ~bus.d_ack)
                 | (((bus.enable_b == SEL_MBR) | (bus.enable_b == SEL_MBRU))
                    & w_f_req & ~bus.f_ack);
  assign w_accept = ~w_stall;

  assign w_mbr_byte = w_f_load ? bus.f_rdata : r_regs[MBR_IDX][MBR_W-1:0];

  // Next register state: C-bus writes, then load results on top.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      w_next[i] = (w_accept && bus.write_c[i]) ? bus.c_bus : r_regs[i];
    end
    w_next[MBR_IDX] = {{(NBITS-MBR_W){1'b0}},
                       (w_f_load ? bus.f_rdata : w_next[MBR_IDX][MBR_W-1:0])};
    w_next[MDR_IDX] = w_d_load ? bus.d_rdata : w_next[MDR_IDX];
  end

  // Register bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= w_next[i];
      end
    end
  end

  // B-bus source mux, bypassing load data during the ack cycle.
  always_comb begin
    w_b_bus = '0;
    if (bus.enable_b == SEL_MBR) begin
      w_b_bus = {{(NBITS-MBR_W){w_mbr_byte[MBR_W-1]}}, w_mbr_byte};
    end else if (bus.enable_b == SEL_MBRU) begin
      w_b_bus = {{(NBITS-MBR_W){1'b0}}, w_mbr_byte};
    end else if (bus.enable_b == SEL_MDR) begin
      w_b_bus = w_d_load ? bus.d_rdata : r_regs[MDR_IDX];
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        w_b_bus = (bus.enable_b == BSEL'(i)) ? r_regs[i] : w_b_bus;
      end
    end
  end

  assign bus.b_bus = w_b_bus;
  assign bus.stall = w_stall;
  assign bus.f_req = w_f_req;

  register_file_hs_mem_channel #(.NBITS(NBITS)) u_d_channel (
    .clk          (clk),
    .reset        (reset),
    .i_rd         (w_rd),
    .i_wr         (w_wr),
    .i_accept     (w_accept),
    .i_ack        (bus.d_ack),
    .i_addr_next  (w_next[MAR_IDX]),
    .i_wdata_next (w_next[MDR_IDX]),
    .o_req        (bus.d_req),
    .o_we         (bus.d_we),
    .o_addr       (bus.d_addr),
    .o_wdata      (bus.d_wdata),
    .o_rd_busy    (w_d_rd_busy),
    .o_load       (w_d_load),
    .o_stall      (w_d_stall)
  );

  register_file_hs_mem_channel #(.NBITS(NBITS)) u_f_channel (
    .clk          (clk),
    .reset        (reset),
    .i_rd         (w_fetch),
    .i_wr         (1'b0),
    .i_accept     (w_accept),
    .i_ack        (bus.f_ack),
    .i_addr_next  (w_next[PC_IDX]),
    .i_wdata_next ({NBITS{1'b0}}),
    .o_req        (w_f_req),
    .o_we         (w_f_we_unused),
    .o_addr       (bus.f_addr),
    .o_wdata      (w_f_wdata_unused),
    .o_rd_busy    (w_f_rd_busy_unused),
    .o_load       (w_f_load),
    .o_stall      (w_f_stall)
  );

endmodule
